// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {IDLE, SHIFT} b2b_state_t;

  localparam int unsigned DIGIT_W = 4;

  // Bits needed for a down-counter that starts at n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the menu path and the 7-segment BCD converter.
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned OUT_DIGITS = 4
) ();

  logic [IN_WIDTH-1:0]           bin_in;
  logic                          in_valid;
  logic                          in_ready;
  logic [DIGIT_W*OUT_DIGITS-1:0] bcd_out;
  logic                          bcd_ovf;
  logic                          out_valid;
  logic                          busy;

  modport master (
    output bin_in, in_valid,
    input  in_ready, bcd_out, bcd_ovf, out_valid, busy
  );

  modport slave (
    input  bin_in, in_valid,
    output in_ready, bcd_out, bcd_ovf, out_valid, busy
  );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // 4-bit add without carry out; a legal digit never exceeds 12 after adjust.
  always_comb begin
    dout = din;
    if (din >= DIGIT_W'(5)) dout = din + DIGIT_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, result registered atomically.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned N_DIGITS   = 5,
  parameter int unsigned OUT_DIGITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int unsigned ACC_W = DIGIT_W * N_DIGITS;
  localparam int unsigned OUT_W = DIGIT_W * OUT_DIGITS;
  localparam int unsigned CNT_W = cnt_width(IN_WIDTH);

  b2b_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [IN_WIDTH-1:0] shreg;
  logic [ACC_W-1:0]    bcd_acc;
  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W-1:0]    acc_shift;
  logic                accept;
  logic                last_shift;

  assign accept     = bus.in_valid & bus.in_ready;
  assign last_shift = (state == SHIFT) && (cnt == '0);

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_acc[g*DIGIT_W +: DIGIT_W]),
      .dout (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Adjusted accumulator shifted left, taking the next binary MSB; top bit is dropped.
  assign acc_shift = ACC_W'({acc_adj, shreg[IN_WIDTH-1]});

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one accept starts IN_WIDTH shifts, the last one returns to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    bus.in_ready = (state == IDLE);
    bus.busy     = (state == SHIFT);
  end

  // Shift register, BCD accumulator and shift counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      shreg   <= '0;
      bcd_acc <= '0;
    end else if (accept) begin
      cnt     <= CNT_W'(IN_WIDTH - 1);
      shreg   <= bus.bin_in;
      bcd_acc <= '0;
    end else if (state == SHIFT) begin
      cnt     <= cnt - CNT_W'(1);
      shreg   <= {shreg[IN_WIDTH-2:0], 1'b0};
      bcd_acc <= acc_shift;
    end
  end

  // Result registers take the final shifted value directly, so they update only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.bcd_out   <= '0;
      bus.bcd_ovf   <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= last_shift;
      if (last_shift) begin
        bus.bcd_out <= acc_shift[OUT_W-1:0];
        bus.bcd_ovf <= |(acc_shift >> OUT_W);
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: decimal reference model, latency and hold checks.
module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.IN_WIDTH(16), .OUT_DIGITS(4)) bus ();

  bin_to_bcd_seq #(.IN_WIDTH(16), .N_DIGITS(5), .OUT_DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned acc_hist[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  logic [15:0] held_bcd = '0;
  logic        held_ovf = 1'b0;

  always @(posedge clk) cyc++;

  // Decimal digits by division, independent of any shift/add formulation.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned p = 1;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard push: an accept is visible half a cycle before the edge that takes it.
  always @(negedge clk) begin
    if (reset && bus.in_valid && bus.in_ready) begin
      exp_t e;
      e.bcd = ref_bcd(int'(bus.bin_in));
      e.ovf = (bus.bin_in > 16'd9999);
      e.due = cyc + 1 + 16;
      sb.push_back(e);
      acc_hist.push_back(cyc + 1);
    end
  end

  // Monitor: reset values, result/latency on out_valid, hold otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      held_bcd = '0;
      held_ovf = 1'b0;
      chk("rst_bcd_out", 32'(bus.bcd_out), 32'h0);
      chk("rst_bcd_ovf", 32'(bus.bcd_ovf), 32'h0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    end else begin
      chk("ready_vs_busy", 32'(bus.in_ready), 32'(!bus.busy));
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          fail_now("spurious out_valid");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
          chk("bcd_ovf", 32'(bus.bcd_ovf), 32'(e.ovf));
          chk("latency", cyc, e.due);
          held_bcd = e.bcd;
          held_ovf = e.ovf;
        end
      end else begin
        chk("hold_bcd_out", 32'(bus.bcd_out), 32'(held_bcd));
        chk("hold_bcd_ovf", 32'(bus.bcd_ovf), 32'(held_ovf));
      end
    end
  end

  task automatic send(input logic [15:0] v);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      fail_now("send timeout");
      return;
    end
    bus.bin_in   = v;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.bin_in   = 16'($urandom);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    if (sb.size() != 0) fail_now("drain timeout");
  endtask

  initial begin
    #2_000_000;
    fail_now("global timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [15:0] dir[5];
    int unsigned a0;
    dir = '{16'd0, 16'd9999, 16'd1234, 16'd12345, 16'hFFFF};
    bus.in_valid = 1'b0;
    bus.bin_in   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Directed values incl. zero, max exact, overflow and full scale.
    foreach (dir[i]) begin
      send(dir[i]);
      wait_drain(40);
    end

    // Request during SHIFT must be ignored.
    a0 = acc_hist.size();
    send(16'd4321);
    repeat (2) @(posedge clk);
    #1;
    bus.bin_in   = 16'd8765;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ign_in_ready", 32'(bus.in_ready), 32'h0);
      chk("ign_busy", 32'(bus.busy), 32'h1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_drain(40);
    chk("ign_accepts", acc_hist.size() - a0, 1);

    // in_valid held high: back-to-back conversions.
    a0 = acc_hist.size();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      bus.bin_in = 16'(100 + k);
      while (acc_hist.size() < a0 + k + 1 && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      if (acc_hist.size() < a0 + k + 1) fail_now("held accept timeout");
    end
    bus.in_valid = 1'b0;
    wait_drain(60);
    if (acc_hist.size() >= a0 + 3) begin
      chk("b2b_interval1", acc_hist[a0+1] - acc_hist[a0], 17);
      chk("b2b_interval2", acc_hist[a0+2] - acc_hist[a0+1], 17);
    end else begin
      fail_now("b2b accept count");
    end

    // Random values, biased half toward the exact range.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] v;
      v = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
      send(v);
      if ($urandom_range(0, 1) == 1) wait_drain(40);
    end
    wait_drain(60);

    // Reset in the middle of a conversion aborts it.
    send(16'd5555);
    wait_drain(40);
    send(16'd42);
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'h1);
    send(16'd42);
    wait_drain(40);

    if (sb.size() != 0) fail_now("scoreboard not empty");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
